// File: rtl/up_counter_ctl_if.sv
// Control/status bundle for up_counter_ctl: count controls in, count state out.
// master drives the controls, slave is the counter itself.
interface up_counter_ctl_if #(
   parameter int WIDTH  = 3,
   parameter int WRAP_W = 8
);
   logic              en;
   logic              clear;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic              oneshot;
   logic [WIDTH-1:0]  data_out;
   logic              tc;
   logic              wrap_pulse;
   logic              done;
   logic [WRAP_W-1:0] wrap_cnt;

   modport master (
      output en, clear, load, load_val, oneshot,
      input  data_out, tc, wrap_pulse, done, wrap_cnt
   );

   modport slave (
      input  en, clear, load, load_val, oneshot,
      output data_out, tc, wrap_pulse, done, wrap_cnt
   );
endinterface

// File: rtl/up_counter_ctl.sv
// Programmable up-counter 0..MAX_VAL with free-run wrap or one-shot halt.
// Optional saturating wrap-event counter enabled by macro UP_COUNTER_WRAP_CNT_EN.
//
// state | meaning
// RUN   | counting while en=1; wraps or halts at MAX_VAL
// HALT  | one-shot finished; holds MAX_VAL until clear/load/reset
module up_counter_ctl #(
   parameter int WIDTH   = 3,
   parameter int MAX_VAL = 7,
   parameter int WRAP_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   up_counter_ctl_if.slave    bus
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

   typedef enum logic {RUN, HALT} state_t;

   state_t           state;
   logic [WIDTH-1:0] count;
   logic             wrap_q;
   logic             done_q;
   logic             at_max;

   assign at_max = (count == MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         count  <= '0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else if (bus.clear) begin
         state  <= RUN;
         count  <= '0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else if (bus.load) begin
         state  <= RUN;
         count  <= (bus.load_val > MAX) ? MAX : bus.load_val;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (state == RUN && bus.en) begin
            if (at_max) begin
               if (bus.oneshot) begin
                  state  <= HALT;
                  done_q <= 1'b1;
               end else begin
                  count  <= '0;
                  wrap_q <= 1'b1;
               end
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

`ifdef UP_COUNTER_WRAP_CNT_EN
   logic              wrap_evt;
   logic [WRAP_W-1:0] wrap_cnt_q;

   // Same qualification as the free-run wrap branch above.
   assign wrap_evt = !bus.clear && !bus.load && (state == RUN) && bus.en
                     && at_max && !bus.oneshot;

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         wrap_cnt_q <= '0;
      end else if (wrap_evt && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
         wrap_cnt_q <= wrap_cnt_q + 1'b1;
      end
   end

   assign bus.wrap_cnt = wrap_cnt_q;
`else
   assign bus.wrap_cnt = {WRAP_W{1'b0}};
`endif

   assign bus.data_out   = count;
   assign bus.tc         = at_max;
   assign bus.wrap_pulse = wrap_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_up_counter_ctl.sv
// Directed bench: DUT a (MAX_VAL=7, WRAP_W=2) and DUT b (MAX_VAL=5) share clk/reset.
module tb_up_counter_ctl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   up_counter_ctl_if #(.WIDTH(3), .WRAP_W(2)) bus_a ();
   up_counter_ctl_if #(.WIDTH(3), .WRAP_W(8)) bus_b ();

   up_counter_ctl #(.WIDTH(3), .MAX_VAL(7), .WRAP_W(2)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   up_counter_ctl #(.WIDTH(3), .MAX_VAL(5), .WRAP_W(8)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_a.en = 0; bus_a.clear = 0; bus_a.load = 0; bus_a.load_val = 0; bus_a.oneshot = 0;
      bus_b.en = 0; bus_b.clear = 0; bus_b.load = 0; bus_b.load_val = 0; bus_b.oneshot = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus_a.data_out !== 3'd0 || bus_a.wrap_pulse !== 1'b0 || bus_a.done !== 1'b0
          || bus_a.wrap_cnt !== 2'd0 || bus_a.tc !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: got data=%0d wrap=%0b done=%0b wcnt=%0d tc=%0b expected 0 0 0 0 0",
                  bus_a.data_out, bus_a.wrap_pulse, bus_a.done, bus_a.wrap_cnt, bus_a.tc);
      end
      checks++;
      if (bus_b.data_out !== 3'd0 || bus_b.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: got data=%0d done=%0b expected 0 0", bus_b.data_out, bus_b.done);
      end
   endtask

   task automatic test_free_run();
      logic [2:0] exp_seq [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
      do_reset();
      bus_a.en = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (bus_a.data_out !== exp_seq[i] || bus_a.wrap_pulse !== (exp_seq[i] == 3'd0)
             || bus_a.tc !== (exp_seq[i] == 3'd7)) begin
            errors++;
            $display("FAIL free_run[%0d]: got data=%0d wrap=%0b tc=%0b expected data=%0d wrap=%0b tc=%0b",
                     i, bus_a.data_out, bus_a.wrap_pulse, bus_a.tc, exp_seq[i],
                     exp_seq[i] == 3'd0, exp_seq[i] == 3'd7);
         end
      end
      bus_a.en = 0;
   endtask

   task automatic test_oneshot();
      do_reset();
      bus_b.en = 1;
      bus_b.oneshot = 1;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if (bus_b.data_out !== 3'(i) || bus_b.done !== 1'b0 || bus_b.tc !== (i == 5)) begin
            errors++;
            $display("FAIL oneshot_count[%0d]: got data=%0d done=%0b tc=%0b expected data=%0d done=0 tc=%0b",
                     i, bus_b.data_out, bus_b.done, bus_b.tc, i, i == 5);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 2) bus_b.oneshot = 0;
         step();
         checks++;
         if (bus_b.data_out !== 3'd5 || bus_b.done !== 1'b1 || bus_b.tc !== 1'b1
             || bus_b.wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_halt[%0d]: got data=%0d done=%0b tc=%0b wrap=%0b expected 5 1 1 0",
                     i, bus_b.data_out, bus_b.done, bus_b.tc, bus_b.wrap_pulse);
         end
      end
      bus_b.oneshot = 1;
   endtask

   task automatic test_load();
      bus_b.en = 0;
      bus_b.load = 1;
      bus_b.load_val = 3'd2;
      step();
      bus_b.load = 0;
      checks++;
      if (bus_b.data_out !== 3'd2 || bus_b.done !== 1'b0) begin
         errors++;
         $display("FAIL load_from_halt: got data=%0d done=%0b expected 2 0", bus_b.data_out, bus_b.done);
      end
      bus_b.en = 1;
      for (int i = 3; i <= 5; i++) begin
         step();
         checks++;
         if (bus_b.data_out !== 3'(i)) begin
            errors++;
            $display("FAIL load_resume[%0d]: got %0d expected %0d", i, bus_b.data_out, i);
         end
      end
      bus_b.en = 0;
      bus_b.load = 1;
      bus_b.load_val = 3'd1;
      step();
      bus_b.load_val = 3'd7;
      step();
      bus_b.load = 0;
      checks++;
      if (bus_b.data_out !== 3'd5 || bus_b.tc !== 1'b1) begin
         errors++;
         $display("FAIL load_saturate: got data=%0d tc=%0b expected 5 1", bus_b.data_out, bus_b.tc);
      end
   endtask

   task automatic test_priority();
      bus_b.oneshot = 1;
      bus_b.load = 1; bus_b.load_val = 3'd4;
      step();
      bus_b.clear = 1; bus_b.load = 1; bus_b.en = 1; bus_b.load_val = 3'd3;
      step();
      bus_b.clear = 0; bus_b.load = 0; bus_b.en = 0;
      checks++;
      if (bus_b.data_out !== 3'd0 || bus_b.done !== 1'b0) begin
         errors++;
         $display("FAIL clear_over_load: got data=%0d done=%0b expected 0 0", bus_b.data_out, bus_b.done);
      end
      bus_b.load = 1; bus_b.load_val = 3'd3;
      step();
      bus_b.load = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus_b.data_out !== 3'd3 || bus_b.wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL hold_en0[%0d]: got data=%0d wrap=%0b expected 3 0", i, bus_b.data_out, bus_b.wrap_pulse);
         end
      end
      bus_b.load = 1; bus_b.load_val = 3'd5; bus_b.en = 1;
      step();
      bus_b.load = 0;
      checks++;
      if (bus_b.data_out !== 3'd5 || bus_b.done !== 1'b0) begin
         errors++;
         $display("FAIL load_over_en: got data=%0d done=%0b expected 5 0", bus_b.data_out, bus_b.done);
      end
      step();
      bus_b.en = 0;
      checks++;
      if (bus_b.data_out !== 3'd5 || bus_b.done !== 1'b1) begin
         errors++;
         $display("FAIL halt_after_load: got data=%0d done=%0b expected 5 1", bus_b.data_out, bus_b.done);
      end
   endtask

   task automatic test_mid_reset();
      bus_a.clear = 1;
      step();
      bus_a.clear = 0;
      bus_a.en = 1;
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (bus_a.data_out !== 3'd6) begin
         errors++;
         $display("FAIL pre_reset_count: got %0d expected 6", bus_a.data_out);
      end
      reset = 1;
      step();
      reset = 0;
      bus_a.en = 0;
      checks++;
      if (bus_a.data_out !== 3'd0 || bus_a.done !== 1'b0 || bus_a.wrap_pulse !== 1'b0
          || bus_a.wrap_cnt !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset_a: got data=%0d done=%0b wrap=%0b wcnt=%0d expected 0 0 0 0",
                  bus_a.data_out, bus_a.done, bus_a.wrap_pulse, bus_a.wrap_cnt);
      end
      checks++;
      if (bus_b.data_out !== 3'd0 || bus_b.done !== 1'b0) begin
         errors++;
         $display("FAIL halt_reset_b: got data=%0d done=%0b expected 0 0", bus_b.data_out, bus_b.done);
      end
   endtask

   task automatic test_wrap_cnt();
      logic [1:0] exp_cnt;
      do_reset();
      bus_a.en = 1;
      for (int w = 1; w <= 5; w++) begin
         for (int s = 0; s < 8; s++) step();
`ifdef UP_COUNTER_WRAP_CNT_EN
         exp_cnt = (w > 3) ? 2'd3 : 2'(w);
`else
         exp_cnt = 2'd0;
`endif
         checks++;
         if (bus_a.wrap_cnt !== exp_cnt || bus_a.wrap_pulse !== 1'b1 || bus_a.data_out !== 3'd0) begin
            errors++;
            $display("FAIL wrap_cnt[%0d]: got wcnt=%0d wrap=%0b data=%0d expected wcnt=%0d wrap=1 data=0",
                     w, bus_a.wrap_cnt, bus_a.wrap_pulse, bus_a.data_out, exp_cnt);
         end
      end
      bus_a.en = 0;
      bus_a.load = 1; bus_a.load_val = 3'd2;
      step();
      bus_a.load = 0;
      checks++;
      if (bus_a.wrap_cnt !== exp_cnt || bus_a.data_out !== 3'd2) begin
         errors++;
         $display("FAIL wrap_cnt_load: got wcnt=%0d data=%0d expected wcnt=%0d data=2",
                  bus_a.wrap_cnt, bus_a.data_out, exp_cnt);
      end
      bus_a.clear = 1;
      step();
      bus_a.clear = 0;
      checks++;
      if (bus_a.wrap_cnt !== 2'd0 || bus_a.data_out !== 3'd0) begin
         errors++;
         $display("FAIL wrap_cnt_clear: got wcnt=%0d data=%0d expected 0 0", bus_a.wrap_cnt, bus_a.data_out);
      end
      bus_a.en = 1; bus_a.oneshot = 1;
      for (int s = 0; s < 8; s++) step();
      bus_a.en = 0; bus_a.oneshot = 0;
      checks++;
      if (bus_a.wrap_cnt !== 2'd0 || bus_a.done !== 1'b1 || bus_a.data_out !== 3'd7
          || bus_a.wrap_pulse !== 1'b0) begin
         errors++;
         $display("FAIL halt_not_wrap: got wcnt=%0d done=%0b data=%0d wrap=%0b expected 0 1 7 0",
                  bus_a.wrap_cnt, bus_a.done, bus_a.data_out, bus_a.wrap_pulse);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_free_run();
      test_oneshot();
      test_load();
      test_priority();
      test_mid_reset();
      test_wrap_cnt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/up_counter_ctl.md
Name: up_counter_ctl

Overview:
Programmable up-counter, the incrementing counterpart of the team's down-counter.
- Counts from 0 to MAX_VAL while enabled, then either wraps to 0 (free-run) or stops and flags done (one-shot).
- Provides terminal-count, wrap-pulse and load/clear controls, so it can serve as a timebase or event counter beside the down-counter in the same datapath.

Parameters:
WIDTH, 3, counter width in bits
MAX_VAL, 7, terminal count value; must satisfy 1 <= MAX_VAL <= 2^WIDTH-1
WRAP_W, 8, width of the optional wrap-event counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
en  in  1  count enable
clear  in  1  synchronous clear to 0
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
oneshot  in  1  1 = stop at MAX_VAL; 0 = wrap
data_out  out  WIDTH  registered count
tc  out  1  combinational, high when data_out == MAX_VAL
wrap_pulse  out  1  registered, one-cycle pulse on the clock edge where the count wraps MAX_VAL -> 0
done  out  1  registered, high while in HALT state
wrap_cnt  out  WRAP_W  wrap-event count (optional feature)

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - Reset is synchronous, active-high.
  - On reset: data_out=0, wrap_pulse=0, done=0, wrap_cnt=0, FSM=RUN.
- Priority per cycle: reset > clear > load > en.
- clear:
  - data_out=0, FSM=RUN, done=0, wrap_pulse=0, wrap_cnt=0.
- load:
  - data_out = load_val, saturated to MAX_VAL if load_val > MAX_VAL.
  - FSM=RUN, done=0, wrap_pulse=0.
  - Allowed in either state; en is ignored that cycle.
- FSM states: RUN, HALT.
  - RUN, en=1, data_out < MAX_VAL: data_out += 1.
  - RUN, en=1, data_out == MAX_VAL, oneshot=0: data_out=0, wrap_pulse=1 next cycle only, wrap_cnt += 1.
  - RUN, en=1, data_out == MAX_VAL, oneshot=1: data_out holds MAX_VAL, FSM -> HALT, done=1 from the next cycle.
  - RUN, en=0: hold all state; wrap_pulse=0.
  - HALT: data_out holds and en is ignored. Exit only via clear, load or reset.
  - oneshot changing while in HALT has no effect.
- wrap_pulse is deasserted in every cycle that is not a wrap.
- Latency: data_out reflects an increment, load or clear one cycle after the qualifying edge inputs.
- tc is purely combinational from data_out: high in HALT and in the final count state of RUN.
- Arithmetic:
  - Increment is modulo MAX_VAL+1, not modulo 2^WIDTH.
  - data_out never exceeds MAX_VAL.
- Boundaries:
  - load and clear in the same cycle: clear wins.
  - load_val == MAX_VAL with en=1 in the same cycle: load wins, so data_out = MAX_VAL. The wrap or halt happens on the next enabled cycle.
  - MAX_VAL = 2^WIDTH-1: wrap path still used, no overflow bits retained.
  - Reset mid-count or in HALT: returns to the full reset state.

Optional Feature:
Macro: UP_COUNTER_WRAP_CNT_EN
- Defined:
  - wrap_cnt increments by 1 on every free-run wrap and saturates at 2^WRAP_W-1; it does not roll over.
  - Cleared by reset or clear; unaffected by load.
  - One-shot halt does not count as a wrap.
- Not defined: no wrap counter register; wrap_cnt is tied to 0. The port remains present so the interface is identical.

Test Plan:
1. Reset, then en=1, oneshot=0, 10 cycles (WIDTH=3, MAX_VAL=7) -> data_out 1,2,3,4,5,6,7,0,1,2. wrap_pulse high exactly on the cycle data_out shows 0. tc high when data_out=7.
2. MAX_VAL=5, oneshot=1, en=1 from reset -> data_out 1..5, then holds 5. done=1 from the cycle after 5 is reached; tc=1. Further en pulses leave data_out=5.
3. In HALT with data_out=5, load=1, load_val=2 -> next cycle data_out=2, done=0, counting resumes 3,4,5. Separately, load_val=7 with MAX_VAL=5 -> data_out=5.
4. load=1, clear=1, en=1 together with data_out=4 -> data_out=0, done=0. Separately, en=0 for 3 cycles at data_out=3 -> data_out stays 3, wrap_pulse=0.
5. Assert reset for one cycle at data_out=6 while en=1 -> data_out=0, done=0, wrap_pulse=0, wrap_cnt=0 on the following cycle.
6. With UP_COUNTER_WRAP_CNT_EN, WRAP_W=2, free-run for 5 wraps -> wrap_cnt 1,2,3,3,3. Without the macro, same stimulus -> wrap_cnt=0 throughout.
